// File: rtl/btb_dm_ctrl.sv
// Direct-mapped branch target buffer with per-entry 2-bit saturating direction counters.
// Define BTB_FLUSH_EN to add the flush_i port that invalidates every entry in one cycle.
module btb_dm_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 16,
  parameter int IDX_LSB = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold_i,
`ifdef BTB_FLUSH_EN
  input  logic              flush_i,
`endif
  input  logic [ADDR_W-1:0] pc_i,
  output logic              pred_hit_o,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o,
  input  logic              res_valid_i,
  input  logic [ADDR_W-1:0] res_pc_i,
  input  logic              res_taken_i,
  input  logic [ADDR_W-1:0] res_target_i,
  output logic              mispredict_o
);

  localparam int IDX_W   = $clog2(DEPTH);
  localparam int TAG_LSB = IDX_LSB + IDX_W;
  localparam int TAG_W   = ADDR_W - TAG_LSB;

  logic [DEPTH-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag    [DEPTH];
  logic [ADDR_W-1:0] r_target [DEPTH];
  logic [1:0]        r_ctr    [DEPTH];

  logic              r_snap_taken;
  logic              r_snap_hit;
  logic [ADDR_W-1:0] r_snap_target;

  logic [IDX_W-1:0]  w_lk_idx;
  logic [TAG_W-1:0]  w_lk_tag;
  logic [IDX_W-1:0]  w_res_idx;
  logic [TAG_W-1:0]  w_res_tag;
  logic              w_res_hit;
  logic              w_upd_en;
  logic              w_snap_pred_taken;

  assign w_lk_idx  = pc_i[IDX_LSB +: IDX_W];
  assign w_lk_tag  = pc_i[ADDR_W-1:TAG_LSB];
  assign w_res_idx = res_pc_i[IDX_LSB +: IDX_W];
  assign w_res_tag = res_pc_i[ADDR_W-1:TAG_LSB];

  assign pred_hit_o    = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag) && (pc_i != '0);
  assign pred_taken_o  = pred_hit_o & r_ctr[w_lk_idx][1];
  assign pred_target_o = pred_taken_o ? r_target[w_lk_idx] : '0;

  // A taken prediction always implies a hit, so gating with snap_hit leaves the result unchanged.
  assign w_snap_pred_taken = r_snap_hit & r_snap_taken;
  assign mispredict_o = res_valid_i &
                        ((res_taken_i != w_snap_pred_taken) |
                         (res_taken_i & (res_target_i != r_snap_target)));

  assign w_res_hit = r_valid[w_res_idx] && (r_tag[w_res_idx] == w_res_tag);
  assign w_upd_en  = res_valid_i && (res_pc_i != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid       <= '0;
      r_snap_taken  <= 1'b0;
      r_snap_hit    <= 1'b0;
      r_snap_target <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b00;
      end
    end
`ifdef BTB_FLUSH_EN
    else if (flush_i) begin
      r_valid       <= '0;
      r_snap_taken  <= 1'b0;
      r_snap_hit    <= 1'b0;
      r_snap_target <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_ctr[i] <= 2'b00;
      end
    end
`endif
    else if (!hold_i) begin
      r_snap_taken  <= pred_taken_o;
      r_snap_hit    <= pred_hit_o;
      r_snap_target <= pred_target_o;
      // Hits train the counter; taken misses evict whatever occupies the slot.
      if (w_upd_en) begin
        if (w_res_hit) begin
          if (res_taken_i) begin
            if (r_ctr[w_res_idx] != 2'b11) r_ctr[w_res_idx] <= r_ctr[w_res_idx] + 2'b01;
            r_target[w_res_idx] <= res_target_i;
          end else if (r_ctr[w_res_idx] != 2'b00) begin
            r_ctr[w_res_idx] <= r_ctr[w_res_idx] - 2'b01;
          end
        end else if (res_taken_i) begin
          r_valid[w_res_idx]  <= 1'b1;
          r_tag[w_res_idx]    <= w_res_tag;
          r_target[w_res_idx] <= res_target_i;
          r_ctr[w_res_idx]    <= 2'b10;
        end
      end
    end
  end

endmodule

// File: doc/btb_dm_ctrl.md
# btb_dm_ctrl

Parametrised direct-mapped branch target buffer with per-entry 2-bit saturating predictors.
- Sits beside the fetch stage: it looks up the fetch PC combinationally and returns a taken prediction and a target.
- Accepts branch resolution from execute, flags mispredictions and trains the table.
- Generalises the single-entry predictor to DEPTH tagged entries with independent counters, and adds optional flush.

## Interface
- ADDR_W, 32, PC and target width.
- DEPTH, 16, number of entries; power of two, ≥2.
- IDX_LSB, 2, lowest PC bit used for the index. The index is pc[IDX_LSB +: log2(DEPTH)]. The tag is pc[ADDR_W-1 : IDX_LSB+log2(DEPTH)].
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- hold_i  in  1  pipeline stall; 1 freezes snapshot and table updates.
- pc_i  in  ADDR_W  fetch PC to look up.
- pred_hit_o  in→out  1  output; valid entry with matching tag and pc_i≠0.
- pred_taken_o  out  1  pred_hit_o & ctr[1].
- pred_target_o  out  ADDR_W  entry target when pred_taken_o, else 0.
- res_valid_i  in  1  a control-transfer instruction resolves this cycle.
- res_pc_i  in  ADDR_W  PC of the resolving instruction.
- res_taken_i  in  1  actual direction.
- res_target_i  in  ADDR_W  actual target; ignored when not taken.
- mispredict_o  out  1  combinational misprediction flag.
- flush_i  in  1  clears all entries; present only with BTB_FLUSH_EN.

## Operation
- Entry fields: valid, tag, target[ADDR_W], ctr[2].
- Counter encoding: 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken.
- Lookup is combinational from the registered table. pc_i==0 never hits.
- Snapshot registers snap_taken, snap_target and snap_hit load {pred_taken_o, pred_target_o, pred_hit_o} on every clk with hold_i==0. They hold when hold_i==1.
- mispredict_o = res_valid_i & ((res_taken_i≠snap_taken) | (res_taken_i & res_target_i≠snap_target)). It is 0 when res_valid_i==0.
- Update condition: res_valid_i & !hold_i. The update uses the index and tag of res_pc_i.
  - Hit & taken: ctr saturating +1 (11 stays 11); target←res_target_i.
  - Hit & not taken: ctr saturating −1 (00 stays 00); target unchanged. The entry stays valid even at 00.
  - Miss & taken: allocate, overwriting any occupant. valid←1, tag, target←res_target_i, ctr←10.
  - Miss & not taken: no change.
  - res_pc_i==0: no change.
- Only one entry is written per cycle. Other entries hold.

## Timing
- Prediction latency is 0 cycles (combinational from pc_i).
- A table update becomes visible to lookup on the cycle after the update edge.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update contents.
- The snapshot has one cycle of latency. Resolution compares against the prediction captured at the last non-held edge.
- Reset (rst_n==0 at a clk edge) clears:
  - all valid bits, ctr←00, target←0, tag←0;
  - snap_* ←0.
- Output values after reset:
  - pred_hit_o, pred_taken_o and pred_target_o = 0;
  - mispredict_o = 0 unless res_valid_i & res_taken_i.
- Reset mid-update: reset wins, and no entry is written.
- hold_i==1 with res_valid_i==1: mispredict_o is still driven; the table and snapshot do not change.

## Configuration
- BTB_FLUSH_EN defined:
  - flush_i port exists.
  - flush_i==1 at a clk edge clears every valid bit and zeroes every ctr, regardless of hold_i.
  - Flush has priority over a same-cycle update, so the update is dropped.
  - Snapshot registers are cleared in the same cycle.
- BTB_FLUSH_EN undefined: flush_i is absent; entries clear only on reset.

## Test plan
- Cold miss + allocate:
  - After reset, pc_i=0x100 → hit=0, taken=0, target=0.
  - Resolve res_pc=0x100, taken=1, target=0x200 → mispredict=1.
  - Next cycle pc_i=0x100 → hit=1, taken=1, target=0x200.
- Counter saturation:
  - Three taken resolves at 0x100 → ctr=11; a fourth keeps 11.
  - Two not-taken resolves → ctr=01, taken=0, hit=1.
  - Two further not-taken resolves → ctr=00; the entry stays valid.
- Aliasing: with DEPTH=16, IDX_LSB=2, resolve taken 0x100→0x200, then taken 0x140→0x300 (same index, different tag) → lookup 0x100 hit=0; lookup 0x140 target=0x300.
- Target change:
  - Entry 0x100 holds ctr=11, target 0x200.
  - Resolve taken with target 0x280 → mispredict=1; the next lookup returns 0x280 with ctr=11.
- Hold: hold_i=1 with res_valid_i=1, taken at a new PC → mispredict_o asserted, table unchanged, snapshot unchanged across the held cycles.
- Flush (BTB_FLUSH_EN): populate 4 entries, then flush_i=1 in the same cycle as a taken update → all lookups hit=0 the next cycle, and the update is not applied.
